// File: rtl/vc_arbiter_wrr.sv
// Arbitrates NUM_VC show-ahead VC FIFOs (strict priority or WRR bursts) and routes each popped word to D0/D1.
// Latency: pop in cycle t -> registered push_dX/DX in cycle t+1; at most one pop per cycle, no bubbles.
// Backpressure: a VC whose destination pop_delay is high is skipped; other eligible VCs are still served.
module vc_arbiter_wrr #(
  parameter int NUM_VC     = 4,
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 5,
  parameter int QUANTUM_W  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_VC*DATA_WIDTH-1:0] vc_data,
  input  logic [NUM_VC-1:0]           vc_empty,
  output logic [NUM_VC-1:0]           vc_pop,
  input  logic                        pop_delay_d0,
  input  logic                        pop_delay_d1,
  input  logic                        mode,
  input  logic [NUM_VC*QUANTUM_W-1:0] quantum,
  output logic [DATA_WIDTH-1:0]       D0,
  output logic [DATA_WIDTH-1:0]       D1,
  output logic                        push_d0,
  output logic                        push_d1,
  output logic [2:0]                  grant_vc,
  output logic                        busy
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                state_q, state_d;
  logic [2:0]            grant_q, grant_d;
  logic [2:0]            rr_q, rr_d;
  logic [QUANTUM_W:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] d0_q, d1_q;
  logic                  push_d0_q, push_d1_q;

  logic [NUM_VC-1:0]     elig;
  logic [QUANTUM_W:0]    quota_eff [NUM_VC];
  logic                  any_elig;
  logic                  found_p, found_r;
  logic [2:0]            prio_win, rr_win, win;
  logic                  grant_elig;
  logic [QUANTUM_W:0]    grant_quota, win_quota;
  logic                  arb;
  logic                  pop_en;
  logic [2:0]            pop_idx;
  logic [DATA_WIDTH-1:0] pop_word;

  // Per-VC eligibility (non-empty and destination not back-pressured) and effective quota (0 counts as 1)
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      elig[i] = !vc_empty[i] &&
                !(vc_data[i*DATA_WIDTH+DEST_BIT] ? pop_delay_d1 : pop_delay_d0);
      quota_eff[i] = (quantum[i*QUANTUM_W +: QUANTUM_W] == '0) ? (QUANTUM_W+1)'(1)
                     : {1'b0, quantum[i*QUANTUM_W +: QUANTUM_W]};
    end
  end

  // Winner selection: lowest eligible index, or first eligible at/after the rr pointer with wrap
  always_comb begin
    found_p  = 1'b0;
    found_r  = 1'b0;
    prio_win = '0;
    rr_win   = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (!found_p && elig[k]) begin
        found_p  = 1'b1;
        prio_win = 3'(k);
      end
      if (!found_r && elig[(int'(rr_q) + k) % NUM_VC]) begin
        found_r = 1'b1;
        rr_win  = 3'((int'(rr_q) + k) % NUM_VC);
      end
    end
    any_elig = |elig;
    win      = mode ? rr_win : prio_win;
  end

  // Look up eligibility/quota of the current grant holder and of the fresh winner
  always_comb begin
    grant_elig  = 1'b0;
    grant_quota = '0;
    win_quota   = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (grant_q == 3'(i)) begin
        grant_elig  = elig[i];
        grant_quota = quota_eff[i];
      end
      if (win == 3'(i)) begin
        win_quota = quota_eff[i];
      end
    end
  end

  // FSM next state: continue a WRR burst while quota and eligibility allow, otherwise re-arbitrate in the same cycle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    pop_en  = 1'b0;
    pop_idx = grant_q;
    arb     = 1'b0;
    case (state_q)
      S_IDLE:  arb = 1'b1;
      S_BURST: begin
        if (grant_elig && (cnt_q < grant_quota)) begin
          pop_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          arb = 1'b1;
        end
      end
      default: arb = 1'b1;
    endcase
    if (arb) begin
      if (any_elig) begin
        pop_en  = 1'b1;
        pop_idx = win;
        grant_d = win;
        cnt_d   = (QUANTUM_W+1)'(1);
        rr_d    = (int'(win) == NUM_VC-1) ? 3'd0 : win + 3'd1;
        state_d = (mode && (win_quota > (QUANTUM_W+1)'(1))) ? S_BURST : S_IDLE;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Popped word mux and one-hot pop strobe, suppressed while reset is asserted
  always_comb begin
    pop_word = '0;
    vc_pop   = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (pop_idx == 3'(i)) begin
        pop_word  = vc_data[i*DATA_WIDTH +: DATA_WIDTH];
        vc_pop[i] = pop_en && !reset;
      end
    end
  end

  // State and output registers; the unselected destination holds its word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      push_d0_q <= pop_en && !pop_word[DEST_BIT];
      push_d1_q <= pop_en && pop_word[DEST_BIT];
      if (pop_en && !pop_word[DEST_BIT]) d0_q <= pop_word;
      if (pop_en && pop_word[DEST_BIT])  d1_q <= pop_word;
    end
  end

  assign D0       = d0_q;
  assign D1       = d1_q;
  assign push_d0  = push_d0_q;
  assign push_d1  = push_d1_q;
  assign grant_vc = grant_q;
  assign busy     = (state_q == S_BURST);

endmodule

// File: tb/tb_vc_arbiter_wrr.sv
// Randomised and directed bench for vc_arbiter_wrr against a queue-free behavioural model of the arbitration rules.
// Each cycle: inputs driven after the rising edge, vc_pop sampled on the falling edge, registered outputs 1ns after the edge.
// Prints one TB_RESULT summary line.
module tb_vc_arbiter_wrr;
  localparam int NV = 4;
  localparam int DW = 6;
  localparam int DB = 5;
  localparam int QW = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NV*DW-1:0]  vc_data = '0;
  logic [NV-1:0]     vc_empty = '1;
  logic [NV-1:0]     vc_pop;
  logic              pop_delay_d0 = 1'b0;
  logic              pop_delay_d1 = 1'b0;
  logic              mode = 1'b0;
  logic [NV*QW-1:0]  quantum = '0;
  logic [DW-1:0]     D0, D1;
  logic              push_d0, push_d1;
  logic [2:0]        grant_vc;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_rr = 0, m_grant = 0, m_cnt = 0;
  bit          m_burst = 0;
  logic [DW-1:0] m_d0 = '0, m_d1 = '0;
  bit          m_p0 = 0, m_p1 = 0;

  vc_arbiter_wrr #(.NUM_VC(NV), .DATA_WIDTH(DW), .DEST_BIT(DB), .QUANTUM_W(QW)) dut (
    .clk(clk), .reset(reset), .vc_data(vc_data), .vc_empty(vc_empty), .vc_pop(vc_pop),
    .pop_delay_d0(pop_delay_d0), .pop_delay_d1(pop_delay_d1), .mode(mode), .quantum(quantum),
    .D0(D0), .D1(D1), .push_d0(push_d0), .push_d1(push_d1), .grant_vc(grant_vc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle with the currently driven inputs; model predicts the pop and the registered results.
  task automatic tick(input bit rst);
    int e[NV];
    int qe[NV];
    int pop;
    int v;
    bit cont;
    logic [DW-1:0] w;
    logic [NV-1:0] exp_pop;
    reset = rst;
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      w     = vc_data[i*DW +: DW];
      e[i]  = (!vc_empty[i] && !(w[DB] ? pop_delay_d1 : pop_delay_d0)) ? 1 : 0;
      qe[i] = (quantum[i*QW +: QW] == 0) ? 1 : int'(quantum[i*QW +: QW]);
    end
    pop  = -1;
    cont = 0;
    if (!rst) begin
      if (m_burst && e[m_grant] != 0 && m_cnt < qe[m_grant]) begin
        pop  = m_grant;
        cont = 1;
      end else begin
        for (int k = 0; k < NV; k++) begin
          v = mode ? (m_rr + k) % NV : k;
          if (pop < 0 && e[v] != 0) pop = v;
        end
      end
    end
    exp_pop = '0;
    if (pop >= 0) exp_pop[pop] = 1'b1;
    check("vc_pop", 32'(vc_pop), 32'(exp_pop));
    @(posedge clk);
    if (rst) begin
      m_rr = 0; m_grant = 0; m_cnt = 0; m_burst = 0;
      m_d0 = '0; m_d1 = '0; m_p0 = 0; m_p1 = 0;
    end else begin
      m_p0 = 0;
      m_p1 = 0;
      if (pop >= 0) begin
        w = vc_data[pop*DW +: DW];
        if (w[DB]) begin m_d1 = w; m_p1 = 1; end
        else       begin m_d0 = w; m_p0 = 1; end
        if (cont) begin
          m_cnt++;
        end else begin
          m_grant = pop;
          m_cnt   = 1;
          m_rr    = (pop + 1) % NV;
          m_burst = mode && (qe[pop] > 1);
        end
      end else begin
        m_burst = 0;
      end
    end
    #1;
    check("D0", 32'(D0), 32'(m_d0));
    check("D1", 32'(D1), 32'(m_d1));
    check("push_d0", 32'(push_d0), 32'(m_p0));
    check("push_d1", 32'(push_d1), 32'(m_p1));
    check("grant_vc", 32'(grant_vc), 32'(m_grant));
    check("busy", 32'(busy), 32'(m_burst));
  endtask

  initial begin
    int seq[9];
    int pushes;
    seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    // reset held two cycles with every VC non-empty; first pop right after release
    vc_empty = '0;
    vc_data  = (NV*DW)'($urandom);
    tick(1);
    tick(1);
    check("rst_grant", 32'(grant_vc), 32'd0);
    tick(0);
    check("first_pop", 32'(push_d0 | push_d1), 32'd1);

    // strict priority: VC0 starves VC2, words land on D1
    mode     = 1'b0;
    vc_data  = {6'b000000, 6'b010110, 6'b000000, 6'b110100};
    vc_empty = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      tick(0);
      check("sp_d1", 32'(D1), 32'(6'b110100));
      check("sp_push_d1", 32'(push_d1), 32'd1);
    end

    // WRR quantum 2, all busy: 0,0,1,1,2,2,3,3,0
    tick(1);
    mode     = 1'b1;
    quantum  = {NV{3'd2}};
    vc_data  = {6'b000011, 6'b000010, 6'b000001, 6'b000000};
    vc_empty = '0;
    for (int n = 0; n < 9; n++) begin
      tick(0);
      check("wrr_seq", 32'(grant_vc), 32'(seq[n]));
      check("wrr_nobubble", 32'(push_d0), 32'd1);
    end

    // VC0 skipped while D1 back-pressured, VC1 served instead
    tick(1);
    quantum      = {NV{3'd1}};
    vc_data      = {6'b000000, 6'b000000, 6'b001100, 6'b100101};
    vc_empty     = 4'b1100;
    pop_delay_d1 = 1'b1;
    tick(0);
    check("skip_d0", 32'(D0), 32'(6'b001100));
    check("skip_push_d0", 32'(push_d0), 32'd1);
    pop_delay_d1 = 1'b0;
    vc_empty     = 4'b1110;
    tick(0);
    check("unskip_d1", 32'(D1), 32'(6'b100101));
    check("unskip_push_d1", 32'(push_d1), 32'd1);

    // all empty, then one VC non-empty for a single cycle
    vc_empty = '1;
    for (int n = 0; n < 3; n++) tick(0);
    check("idle_busy", 32'(busy), 32'd0);
    pushes   = 0;
    vc_empty = 4'b1011;
    tick(0);
    pushes += int'(push_d0) + int'(push_d1);
    vc_empty = '1;
    tick(0);
    pushes += int'(push_d0) + int'(push_d1);
    check("single_push", 32'(pushes), 32'd1);

    // reset on the second word of a quantum-4 burst
    tick(1);
    quantum  = {NV{3'd4}};
    vc_data  = (NV*DW)'($urandom);
    vc_empty = '0;
    tick(0);
    tick(1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_push", 32'(push_d0 | push_d1), 32'd0);
    tick(0);
    check("restart_vc0", 32'(grant_vc), 32'd0);

    // randomised traffic, modes, quotas, back-pressure and occasional resets
    for (int n = 0; n < 800; n++) begin
      vc_data  = (NV*DW)'($urandom);
      vc_empty = NV'($urandom & $urandom);
      pop_delay_d0 = ($urandom_range(0, 3) == 0);
      pop_delay_d1 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) quantum = (NV*QW)'($urandom);
      tick($urandom_range(0, 59) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
